fifo_par_flow: RTL

Parametrised circular-buffer FIFO with a variable number of lanes per write and a fixed number of lanes per read.
- Valid/ready handshakes on both sides.
- Exact occupancy count and programmable almost-full / almost-empty flags.
- DEPTH need not be a power of two.
- Sits between a multi-sample producer (e.g. a PAR_WRITE-wide filter stage) and a PAR_READ-wide consumer in the datapath.

---
 rtl/fifo_par_flow_pkg.sv | 12 +
 rtl/fifo_par_flow_if.sv | 31 +++
 rtl/fifo_par_flow_ptr_mod_counter.sv | 29 ++
 rtl/fifo_par_flow.sv | 65 ++++++
 4 files changed

// File: rtl/fifo_par_flow_pkg.sv
// fifo_par_flow_pkg: shared width helpers for the parallel-lane FIFO
package fifo_par_flow_pkg;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int ptr_w(input int depth);
    return idx_w(depth);
  endfunction
  function automatic int count_w(input int depth);
    return idx_w(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_par_flow_if.sv
// fifo_par_flow_if: producer/consumer handshake bundle of the parallel-lane FIFO
interface fifo_par_flow_if
  import fifo_par_flow_pkg::*;
#(
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ = 3,
  parameter int DEPTH = 10,
  parameter int BITS = 16
);
  logic wr_valid;
  logic [idx_w(PAR_WRITE + 1)-1:0] wr_num;
  logic [BITS*PAR_WRITE-1:0] din;
  logic wr_ready;
  logic wr_drop;
  logic rd_ready;
  logic rd_valid;
  logic [BITS*PAR_READ-1:0] dout;
  logic [count_w(DEPTH)-1:0] count;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  modport master (
    output wr_valid, wr_num, din, rd_ready,
    input wr_ready, wr_drop, rd_valid, dout, count, full, empty, almost_full, almost_empty
  );
  modport slave (
    input wr_valid, wr_num, din, rd_ready,
    output wr_ready, wr_drop, rd_valid, dout, count, full, empty, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_par_flow_ptr_mod_counter.sv
// ptr_mod_counter: modulo-DEPTH pointer with variable step and per-lane wrapped addresses
module ptr_mod_counter
  import fifo_par_flow_pkg::*;
#(
  parameter int BITS = 2,
  parameter int DEPTH = 10,
  parameter int MAX_STEP = 2
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic [BITS-1:0] step,
  output logic [ptr_w(DEPTH)-1:0] ptr,
  output logic [MAX_STEP*ptr_w(DEPTH)-1:0] ptr_plus
);
  localparam int PW = ptr_w(DEPTH);
  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [PW:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + n;
    return s >= (PW+1)'(DEPTH) ? PW'(s - (PW+1)'(DEPTH)) : PW'(s);
  endfunction
  for (genvar i = 0; i < MAX_STEP; i++) begin : g_lane
    assign ptr_plus[i*PW +: PW] = adv(ptr, (PW+1)'(i));
  end
  // Advance by the accepted step, wrapping at DEPTH
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (en) ptr <= adv(ptr, (PW+1)'(step));
endmodule

// File: rtl/fifo_par_flow.sv
// fifo_par_flow: multi-lane write / fixed-lane read circular-buffer FIFO with occupancy flags
module fifo_par_flow
  import fifo_par_flow_pkg::*;
#(
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ = 3,
  parameter int DEPTH = 10,
  parameter int BITS = 16,
  parameter int AF_LEVEL = 8,
  parameter int AE_LEVEL = 2
) (
  input logic clk,
  input logic rst,
  fifo_par_flow_if.slave bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam int NW = idx_w(PAR_WRITE + 1);
  localparam int RW = idx_w(PAR_READ + 1);
  if (DEPTH < PAR_WRITE || DEPTH < PAR_READ || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_cfg
    $fatal(1, "fifo_par_flow: illegal parameter combination");
  end
  logic [BITS-1:0] mem [DEPTH];
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PAR_WRITE*PW-1:0] wr_addr;
  logic [PAR_READ*PW-1:0] rd_addr;
  logic [PW:0] span;
  logic legal, wa, ra;
  assign legal = bus.wr_num != '0 && bus.wr_num <= NW'(PAR_WRITE);
  assign bus.wr_ready = (CW+1)'(DEPTH) - {1'b0, count_q} >= (CW+1)'(PAR_WRITE);
  assign bus.rd_valid = count_q >= CW'(PAR_READ);
  assign wa = ~rst & bus.wr_valid & bus.wr_ready & legal;
  assign ra = ~rst & bus.rd_valid & bus.rd_ready;
  assign bus.count = count_q;
  assign bus.full = count_q == CW'(DEPTH);
  assign bus.empty = count_q == '0;
  assign bus.almost_full = count_q >= CW'(AF_LEVEL);
  assign bus.almost_empty = count_q <= CW'(AE_LEVEL);
  assign span = wr_ptr >= rd_ptr ? {1'b0, wr_ptr} - {1'b0, rd_ptr}
                                 : {1'b0, wr_ptr} + (PW+1)'(DEPTH) - {1'b0, rd_ptr};
  ptr_mod_counter #(.BITS(NW), .DEPTH(DEPTH), .MAX_STEP(PAR_WRITE)) u_wr_ptr (
    .clk(clk), .rst(rst), .en(wa), .step(bus.wr_num), .ptr(wr_ptr), .ptr_plus(wr_addr)
  );
  ptr_mod_counter #(.BITS(RW), .DEPTH(DEPTH), .MAX_STEP(PAR_READ)) u_rd_ptr (
    .clk(clk), .rst(rst), .en(ra), .step(RW'(PAR_READ)), .ptr(rd_ptr), .ptr_plus(rd_addr)
  );
  for (genvar i = 0; i < PAR_READ; i++) begin : g_rd
    assign bus.dout[i*BITS +: BITS] = mem[rd_addr[i*PW +: PW]];
  end
  // Store the accepted lanes; storage is deliberately left unreset
  always_ff @(posedge clk)
    for (int i = 0; i < PAR_WRITE; i++)
      if (wa && NW'(i) < bus.wr_num) mem[wr_addr[i*PW +: PW]] <= bus.din[i*BITS +: BITS];
  // Occupancy tracks accepted writes minus accepted reads
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else count_q <= count_q + (wa ? CW'(bus.wr_num) : CW'(0)) - (ra ? CW'(PAR_READ) : CW'(0));
  // Flag refused or malformed write requests one cycle later
  always_ff @(posedge clk)
    bus.wr_drop <= ~rst & bus.wr_valid & (~bus.wr_ready | ~legal);
  // Occupancy must stay consistent with the pointer distance
  always_ff @(posedge clk)
    if (!rst) assert (count_q <= CW'(DEPTH) && span == (PW+1)'(count_q == CW'(DEPTH) ? CW'(0) : count_q));
endmodule
